load_sequencer: RTL and testbench
=================================

# load_sequencer

Hardwired control sequencer for the load family (`ld`, `ldi`) of the ELEC374 datapath. It is the reader counterpart to the store sequence. It fetches the instruction, computes the effective address `Rb + C` (or `C` when Rb is R0, via BAout), reads memory into MDR and writes the result into Ra. It sits beside `CPUproject` and drives that block's control inputs one T-state per clock.

## Interface
Parameters
- `MEM_WAIT`, default 1: number of cycles Read/MDRin are held in each memory-read state. Legal range 1–15.
- `OP_LD`, default 5'b00000: opcode of `ld`.
- `OP_LDI`, default 5'b00001: opcode of `ldi`.

Ports
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `start` in 1: begin an instruction; sampled only in IDLE.
- `ir_opcode` in 5: IR[31:27] from the datapath; sampled in T3.
- `PCout`, `MARin`, `IncPC`, `ZHighIn`, `ZLowIn`, `ZLowout`, `PCin` out 1 each: fetch and address strobes.
- `Read`, `MDRin`, `MDRout`, `IRin` out 1 each: memory and IR strobes.
- `Grb`, `BAout`, `Yin`, `Cout`, `Gra`, `R_in` out 1 each: register-file and operand strobes.
- `alu_add` out 1: selects the ALU ADD operation.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse during the register-write state.
- `err` out 1: one-cycle pulse for an illegal opcode.
- `state_dbg` out 4: current state encoding.

## Operation
- Moore FSM with a registered state. Outputs are decoded from the state only.
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, ERR=9.
- Strobes asserted in each state:
  - IDLE: none. Next state is T0 if `start`, else IDLE.
  - T0: PCout, MARin, IncPC, ZHighIn, ZLowIn.
  - T1: ZLowout, PCin, Read, MDRin. Held `MEM_WAIT` cycles; PCin is asserted only in the first of them.
  - T2: MDRout, IRin.
  - T3: Grb, BAout, Yin. Opcode is checked here:
    - `OP_LD` → T4.
    - `OP_LDI` → T4 (when the macro is defined).
    - Anything else → ERR.
  - T4: Cout, alu_add, ZHighIn, ZLowIn.
  - T5 for ld: ZLowout, MARin → T6.
  - T5 for ldi: ZLowout, Gra, R_in, done → IDLE.
  - T6: Read, MDRin. Held `MEM_WAIT` cycles.
  - T7: MDRout, Gra, R_in, done → IDLE.
  - ERR: err → IDLE. No register write occurs.
- A 1-bit `is_ldi` flag is latched in T3 and steers the T5 branch.
- A 4-bit wait counter loads `MEM_WAIT-1` on entry to T1 or T6 and decrements each cycle. The state advances when the counter is 0.
- `start` while busy is ignored. It is not queued.
- `ir_opcode` is ignored outside T3.

## Timing
- Reset (clr=0, at any time, including mid-instruction):
  - state → IDLE, counter → 0, `is_ldi` → 0.
  - Every output is 0, `state_dbg`=0, immediately and without waiting for a clock edge.
- `start` sampled high at edge k → T0 in cycle k+1.
- ld: busy for 8 + 2·(MEM_WAIT−1) cycles. `done` falls in the last of them.
- ldi: busy for 6 + (MEM_WAIT−1) cycles.
- Illegal opcode: busy for 5 + (MEM_WAIT−1) cycles (T0, T1 incl. wait, T2, T3, ERR).
- At least one IDLE cycle always separates instructions.
- `done` and `err` are never high together. Each is high for exactly one cycle.
- IncPC is high only in T0, so PC increments exactly once per instruction.

## Configuration
- `LOAD_SEQ_LDI_EN` defined: `OP_LDI` is decoded and takes the T5 write branch.
- `LOAD_SEQ_LDI_EN` undefined: `OP_LDI` is treated as illegal (→ ERR), and the `is_ldi` flag is removed.

## Test plan
- MEM_WAIT=1, start pulse, opcode 00000 (`ld R2,0x55(R0)`) → states T0..T7 in 8 consecutive cycles. BAout in T3 only. `done` and R_in high together in cycle 8. IncPC high exactly once.
- Macro defined, opcode 00001 (`ldi R3,0x20(R1)`) → 6 busy cycles. Gra, R_in and done high in T5. Read high exactly once (T1).
- MEM_WAIT=3, ld → T1 and T6 each last 3 cycles. Busy is 12 cycles. PCin high for 1 cycle.
- Opcode 00010 (`st`) → err pulses in cycle 5. R_in and done never assert. busy drops in cycle 6.
- clr low mid-T6 → all outputs 0 and `state_dbg`=0 in the same cycle. After release, a new start runs a full ld normally.
- start held high throughout → one IDLE cycle between instructions. `start` asserted during T2 has no effect on the sequence.

Source files
------------

// File: rtl/load_sequencer.sv
// Hardwired Moore control sequencer for the ld/ldi load family: fetch, effective address, memory
// read into MDR, register write. Define LOAD_SEQ_LDI_EN to decode ldi; otherwise ldi traps to ERR.
module load_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [4:0]  OP_LD    = 5'b00000,
    parameter logic [4:0]  OP_LDI   = 5'b00001
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [4:0] ir_opcode,
    output logic       PCout,
    output logic       MARin,
    output logic       IncPC,
    output logic       ZHighIn,
    output logic       ZLowIn,
    output logic       ZLowout,
    output logic       PCin,
    output logic       Read,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Grb,
    output logic       BAout,
    output logic       Yin,
    output logic       Cout,
    output logic       Gra,
    output logic       R_in,
    output logic       alu_add,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StT3   = 4'd4;
    localparam logic [3:0] StT4   = 4'd5;
    localparam logic [3:0] StT5   = 4'd6;
    localparam logic [3:0] StT6   = 4'd7;
    localparam logic [3:0] StT7   = 4'd8;
    localparam logic [3:0] StErr  = 4'd9;

    localparam logic [3:0] WaitLoad = 4'(MEM_WAIT - 1);

    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ldi_sel;

`ifdef LOAD_SEQ_LDI_EN
    logic is_ldi_q, is_ldi_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            is_ldi_q <= 1'b0;
        end else begin
            is_ldi_q <= is_ldi_d;
        end
    end

    assign ldi_sel = is_ldi_q;
`else
    assign ldi_sel = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef LOAD_SEQ_LDI_EN
        is_ldi_d = is_ldi_q;
`endif
        case (state_q)
            StIdle: if (start) state_d = StT0;
            StT0: begin
                state_d = StT1;
                cnt_d   = WaitLoad;
            end
            StT1: begin
                if (cnt_q == 4'd0) state_d = StT2;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StT2: state_d = StT3;
            StT3: begin
`ifdef LOAD_SEQ_LDI_EN
                if (ir_opcode == OP_LD) begin
                    state_d  = StT4;
                    is_ldi_d = 1'b0;
                end else if (ir_opcode == OP_LDI) begin
                    state_d  = StT4;
                    is_ldi_d = 1'b1;
                end else begin
                    state_d  = StErr;
                    is_ldi_d = 1'b0;
                end
`else
                // ldi support compiled out: its opcode is rejected explicitly
                if (ir_opcode == OP_LD && ir_opcode != OP_LDI) state_d = StT4;
                else                                           state_d = StErr;
`endif
            end
            StT4: state_d = StT5;
            StT5: begin
                if (ldi_sel) begin
                    state_d = StIdle;
                end else begin
                    state_d = StT6;
                    cnt_d   = WaitLoad;
                end
            end
            StT6: begin
                if (cnt_q == 4'd0) state_d = StT7;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StT7:    state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        ZHighIn = 1'b0;
        ZLowIn  = 1'b0;
        ZLowout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Grb     = 1'b0;
        BAout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        Gra     = 1'b0;
        R_in    = 1'b0;
        alu_add = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        busy    = (state_q != StIdle);
        case (state_q)
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            StT1: begin
                ZLowout = 1'b1;
                // counter still holds its load value only in the first wait cycle
                PCin    = (cnt_q == WaitLoad);
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Grb   = 1'b1;
                BAout = 1'b1;
                Yin   = 1'b1;
            end
            StT4: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                ZHighIn = 1'b1;
                ZLowIn  = 1'b1;
            end
            StT5: begin
                ZLowout = 1'b1;
                if (ldi_sel) begin
                    Gra  = 1'b1;
                    R_in = 1'b1;
                    done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            StT6: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StT7: begin
                MDRout = 1'b1;
                Gra    = 1'b1;
                R_in   = 1'b1;
                done   = 1'b1;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Scoreboard bench for load_sequencer: two instances (MEM_WAIT=1 and 3), per-cycle expected
// output vectors queued by the stimulus and popped by a monitor on each falling edge.
module tb_load_sequencer;

    // vector layout: [24:21] state_dbg, then strobes, [2] busy, [1] done, [0] err
    localparam logic [24:0] B_PCOUT   = 25'h1 << 20;
    localparam logic [24:0] B_MARIN   = 25'h1 << 19;
    localparam logic [24:0] B_INCPC   = 25'h1 << 18;
    localparam logic [24:0] B_ZHI     = 25'h1 << 17;
    localparam logic [24:0] B_ZLO     = 25'h1 << 16;
    localparam logic [24:0] B_ZLOWOUT = 25'h1 << 15;
    localparam logic [24:0] B_PCIN    = 25'h1 << 14;
    localparam logic [24:0] B_READ    = 25'h1 << 13;
    localparam logic [24:0] B_MDRIN   = 25'h1 << 12;
    localparam logic [24:0] B_MDROUT  = 25'h1 << 11;
    localparam logic [24:0] B_IRIN    = 25'h1 << 10;
    localparam logic [24:0] B_GRB     = 25'h1 << 9;
    localparam logic [24:0] B_BAOUT   = 25'h1 << 8;
    localparam logic [24:0] B_YIN     = 25'h1 << 7;
    localparam logic [24:0] B_COUT    = 25'h1 << 6;
    localparam logic [24:0] B_GRA     = 25'h1 << 5;
    localparam logic [24:0] B_RIN     = 25'h1 << 4;
    localparam logic [24:0] B_ADD     = 25'h1 << 3;
    localparam logic [24:0] B_BUSY    = 25'h1 << 2;
    localparam logic [24:0] B_DONE    = 25'h1 << 1;
    localparam logic [24:0] B_ERR     = 25'h1;

    logic       clk;
    logic       clr;
    logic       start0;
    logic       start1;
    logic [4:0] op;
    wire [24:0] v0;
    wire [24:0] v1;

    int errors = 0;
    int checks = 0;
    logic [24:0] q0[$];
    logic [24:0] q1[$];

    load_sequencer #(.MEM_WAIT(1)) u_seq1 (
        .clk(clk), .clr(clr), .start(start0), .ir_opcode(op),
        .PCout(v0[20]), .MARin(v0[19]), .IncPC(v0[18]), .ZHighIn(v0[17]), .ZLowIn(v0[16]),
        .ZLowout(v0[15]), .PCin(v0[14]), .Read(v0[13]), .MDRin(v0[12]), .MDRout(v0[11]),
        .IRin(v0[10]), .Grb(v0[9]), .BAout(v0[8]), .Yin(v0[7]), .Cout(v0[6]), .Gra(v0[5]),
        .R_in(v0[4]), .alu_add(v0[3]), .busy(v0[2]), .done(v0[1]), .err(v0[0]),
        .state_dbg(v0[24:21])
    );

    load_sequencer #(.MEM_WAIT(3)) u_seq3 (
        .clk(clk), .clr(clr), .start(start1), .ir_opcode(op),
        .PCout(v1[20]), .MARin(v1[19]), .IncPC(v1[18]), .ZHighIn(v1[17]), .ZLowIn(v1[16]),
        .ZLowout(v1[15]), .PCin(v1[14]), .Read(v1[13]), .MDRin(v1[12]), .MDRout(v1[11]),
        .IRin(v1[10]), .Grb(v1[9]), .BAout(v1[8]), .Yin(v1[7]), .Cout(v1[6]), .Gra(v1[5]),
        .R_in(v1[4]), .alu_add(v1[3]), .busy(v1[2]), .done(v1[1]), .err(v1[0]),
        .state_dbg(v1[24:21])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] st(input int n);
        return 25'(n) << 21;
    endfunction

    task automatic push(input int d, input logic [24:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic push_fetch(input int d, input int mw);
        push(d, st(1) | B_PCOUT | B_MARIN | B_INCPC | B_ZHI | B_ZLO | B_BUSY);
        push(d, st(2) | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_BUSY);
        for (int i = 1; i < mw; i++) push(d, st(2) | B_ZLOWOUT | B_READ | B_MDRIN | B_BUSY);
        push(d, st(3) | B_MDROUT | B_IRIN | B_BUSY);
        push(d, st(4) | B_GRB | B_BAOUT | B_YIN | B_BUSY);
    endtask

    task automatic push_ld(input int d, input int mw);
        push_fetch(d, mw);
        push(d, st(5) | B_COUT | B_ADD | B_ZHI | B_ZLO | B_BUSY);
        push(d, st(6) | B_ZLOWOUT | B_MARIN | B_BUSY);
        for (int i = 0; i < mw; i++) push(d, st(7) | B_READ | B_MDRIN | B_BUSY);
        push(d, st(8) | B_MDROUT | B_GRA | B_RIN | B_DONE | B_BUSY);
    endtask

    task automatic push_err(input int d, input int mw);
        push_fetch(d, mw);
        push(d, st(9) | B_ERR | B_BUSY);
    endtask

    task automatic push_ldi(input int d, input int mw);
`ifdef LOAD_SEQ_LDI_EN
        push_fetch(d, mw);
        push(d, st(5) | B_COUT | B_ADD | B_ZHI | B_ZLO | B_BUSY);
        push(d, st(6) | B_ZLOWOUT | B_GRA | B_RIN | B_DONE | B_BUSY);
`else
        push_err(d, mw);
`endif
    endtask

    task automatic set_start(input int d, input logic val);
        if (d == 0) start0 = val;
        else        start1 = val;
    endtask

    // Raise start just after a falling edge so the next rising edge samples it.
    task automatic issue(input int d, input logic [4:0] opcode, input int kind);
        @(negedge clk); #1;
        op = opcode;
        set_start(d, 1'b1);
        case (kind)
            0:       push_ld(d, (d == 0) ? 1 : 3);
            1:       push_ldi(d, (d == 0) ? 1 : 3);
            default: push_err(d, (d == 0) ? 1 : 3);
        endcase
        @(negedge clk); #1;
        set_start(d, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) begin
            @(negedge clk); #1;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout: %0d/%0d entries left, required 0", name,
                     q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0 || v0[2]) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL seq_mw1 unexpected busy: got=%h required idle", v0);
            end else begin
                logic [24:0] e;
                e = q0.pop_front();
                if (v0 !== e) begin
                    errors++;
                    $display("FAIL seq_mw1 got=%h required=%h", v0, e);
                end
            end
        end else begin
            checks++;
            if (v0 !== 25'h0) begin
                errors++;
                $display("FAIL idle_mw1 got=%h required=0", v0);
            end
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0 || v1[2]) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL seq_mw3 unexpected busy: got=%h required idle", v1);
            end else begin
                logic [24:0] e;
                e = q1.pop_front();
                if (v1 !== e) begin
                    errors++;
                    $display("FAIL seq_mw3 got=%h required=%h", v1, e);
                end
            end
        end else begin
            checks++;
            if (v1 !== 25'h0) begin
                errors++;
                $display("FAIL idle_mw3 got=%h required=0", v1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        op     = 5'b00000;
        repeat (2) @(negedge clk);
        #1;
        clr = 1'b1;

        issue(0, 5'b00000, 0);   // ld R2,0x55(R0)
        wait_drain("ld_mw1");
        issue(0, 5'b00001, 1);   // ldi R3,0x20(R1)
        wait_drain("ldi_mw1");
        issue(1, 5'b00000, 0);   // ld with 3-cycle memory wait
        wait_drain("ld_mw3");
        issue(0, 5'b00010, 2);   // st opcode is illegal here
        wait_drain("illegal_mw1");
        issue(1, 5'b00011, 2);
        wait_drain("illegal_mw3");

        // Asynchronous reset in the middle of T6 (cycle 10 of a MEM_WAIT=3 ld).
        issue(1, 5'b00000, 0);
        repeat (9) @(negedge clk);
        #1;
        clr = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        checks++;
        if (v1 !== 25'h0) begin
            errors++;
            $display("FAIL clr_async got=%h required=0", v1);
        end
        @(negedge clk); #1;
        clr = 1'b1;
        issue(1, 5'b00000, 0);
        wait_drain("ld_after_clr");

        // start held high: two back-to-back lds separated by exactly one IDLE cycle.
        @(negedge clk); #1;
        op     = 5'b00000;
        start0 = 1'b1;
        push_ld(0, 1);
        push(0, 25'h0);
        push_ld(0, 1);
        repeat (17) @(negedge clk);
        #1;
        start0 = 1'b0;
        wait_drain("start_held");

        // start raised while in T2 must not queue a second instruction.
        issue(1, 5'b00000, 0);
        repeat (4) @(negedge clk);
        #1;
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        wait_drain("start_in_t2");
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
